// File: rtl/debounce_filter.sv
// Purpose: debounces one bouncy level input into a clean level with rise/fall strobes.
// Latency: DEBOUNCE_LIMIT samples from first sampled step to o_Debounced change (+2 with the synchronizer).
// Backpressure: none; free-running filter that samples every i_Clk rising edge.
//
// Ports:
//   i_Clk       - system clock, rising edge
//   i_Rst_L     - asynchronous active-low reset
//   i_Bouncy    - raw input level
//   o_Debounced - filtered level (RESET_LEVEL after reset)
//   o_Rise      - one-cycle strobe on an accepted 0->1 change
//   o_Fall      - one-cycle strobe on an accepted 1->0 change
//   o_Busy      - high while a candidate change is being counted
//
// Build option: define DEBOUNCE_FILTER_SYNC_EN to put a 2-flop synchronizer
// in front of the filter, for inputs that are asynchronous to i_Clk.
module debounce_filter #(
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Bouncy,
    output logic o_Debounced,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Busy
);

    generate
        if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
            $error("debounce_filter: DEBOUNCE_LIMIT must be >= 2");
        end
    endgenerate

    localparam int            CW      = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

    logic          sample;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          busy_q, busy_d;

`ifdef DEBOUNCE_FILTER_SYNC_EN
    // Two-stage synchronizer; both stages reset to RESET_LEVEL so that
    // releasing reset never looks like a pending change.
    logic [1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[0], i_Bouncy};
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q <= {2{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sample = sync_q[1];
`else
    assign sample = i_Bouncy;
`endif

    // Count consecutive samples that differ from the current output. Any
    // sample matching the output restarts qualification from zero. The
    // counter stops at CNT_MAX, where the change is accepted, so it never wraps.
    always_comb begin
        cnt_d  = '0;
        deb_d  = deb_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sample != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d  = sample;
                rise_d = sample;
                fall_d = ~sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Registered busy tracks the count register it is stored alongside.
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q  <= '0;
            deb_q  <= RESET_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            busy_q <= busy_d;
        end
    end

    assign o_Debounced = deb_q;
    assign o_Rise      = rise_q;
    assign o_Fall      = fall_q;
    assign o_Busy      = busy_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Purpose: directed, table-driven check of debounce_filter with DEBOUNCE_LIMIT=4.
// Latency: expectations are written for the direct build; the synchronized build shifts them by 2 steps.
// Backpressure: n/a.
module tb_debounce_filter;

    localparam int LIMIT = 4;
`ifdef DEBOUNCE_FILTER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic i_Clk;
    logic i_Rst_L;
    logic i_Bouncy;
    logic o_Debounced;
    logic o_Rise;
    logic o_Fall;
    logic o_Busy;

    debounce_filter #(
        .DEBOUNCE_LIMIT(LIMIT),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Bouncy   (i_Bouncy),
        .o_Debounced(o_Debounced),
        .o_Rise     (o_Rise),
        .o_Fall     (o_Fall),
        .o_Busy     (o_Busy)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Expected outputs packed as {debounced, rise, fall, busy}.
    typedef struct packed {
        logic       b;
        logic [3:0] exp;
    } vec_t;

    localparam int NVEC = 41;
    vec_t tbl [NVEC];

    int n_vec;
    int n_err;

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {o_Debounced, o_Rise, o_Fall, o_Busy};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got deb/rise/fall/busy=%b, expected %b", name, got, exp);
        end
    endtask

    // Drive one input sample, let one rising edge take it, then look at outputs.
    task automatic step(input logic b);
        i_Bouncy = b;
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        i_Rst_L  = 1'b0;
        i_Bouncy = 1'b0;

        // Idle after reset.
        tbl[0]  = '{1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 4'b0000};
        tbl[2]  = '{1'b0, 4'b0000};
        // One-cycle glitch high, then back low: count restarts.
        tbl[3]  = '{1'b1, 4'b0001};
        tbl[4]  = '{1'b0, 4'b0000};
        // Held high: accepted on the 4th sample with a single rise strobe.
        tbl[5]  = '{1'b1, 4'b0001};
        tbl[6]  = '{1'b1, 4'b0001};
        tbl[7]  = '{1'b1, 4'b0001};
        tbl[8]  = '{1'b1, 4'b1100};
        tbl[9]  = '{1'b1, 4'b1000};
        tbl[10] = '{1'b1, 4'b1000};
        // Held low: busy for three cycles, then fall strobe.
        tbl[11] = '{1'b0, 4'b1001};
        tbl[12] = '{1'b0, 4'b1001};
        tbl[13] = '{1'b0, 4'b1001};
        tbl[14] = '{1'b0, 4'b0010};
        tbl[15] = '{1'b0, 4'b0000};
        // Returning to current level on the final qualifying sample.
        tbl[16] = '{1'b1, 4'b0001};
        tbl[17] = '{1'b1, 4'b0001};
        tbl[18] = '{1'b1, 4'b0001};
        tbl[19] = '{1'b0, 4'b0000};
        tbl[20] = '{1'b0, 4'b0000};
        // Toggling every cycle for 20 cycles: output never moves.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) tbl[21 + i] = '{1'b1, 4'b0001};
            else            tbl[21 + i] = '{1'b0, 4'b0000};
        end

        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        check("reset_state", 4'b0000);
        i_Rst_L = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].b);
            if (i >= SYNC_LAT) check($sformatf("vec%0d", i), tbl[i - SYNC_LAT].exp);
            else               check($sformatf("vec%0d", i), 4'b0000);
        end

        // Settle low, then qualify a rise to set up the mid-count reset case.
        repeat (4) step(1'b0);
        for (int i = 0; i < LIMIT + SYNC_LAT - 1; i++) begin
            step(1'b1);
            check($sformatf("pre_rise%0d", i), (i >= SYNC_LAT) ? 4'b0001 : 4'b0000);
        end
        step(1'b1);
        check("rise_accept", 4'b1100);
        // Two low samples reach the filter: count = 2, output still 1.
        for (int i = 0; i < SYNC_LAT + 2; i++) begin
            step(1'b0);
            check($sformatf("count_up%0d", i), (i >= SYNC_LAT) ? 4'b1001 : 4'b1000);
        end

        // Assert reset between edges; outputs must clear without a clock edge.
        #2;
        i_Rst_L = 1'b0;
        #1;
        check("async_reset", 4'b0000);
        @(negedge i_Clk);
        check("reset_held", 4'b0000);
        i_Rst_L = 1'b1;

        // Held low after reset matches RESET_LEVEL: nothing happens.
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
            check($sformatf("post_reset%0d", i), 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
